// File: rtl/wb_merge.sv
// Multi-lane writeback merge: drops WAW losers and x0 writes, buffers survivors in order,
// drains up to WPORTS per cycle to the register file, and answers bypass queries.
module wb_merge #(
    parameter int unsigned LANES  = 2,
    parameter int unsigned WPORTS = 1,
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned QPORTS = 2,
    parameter int unsigned ADDR_W = 5,
    parameter int unsigned DATA_W = 32
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [LANES-1:0]           in_we,
    input  logic [LANES*ADDR_W-1:0]    in_waddr,
    input  logic [LANES*DATA_W-1:0]    in_wdata,
    output logic [WPORTS-1:0]          rf_we,
    output logic [WPORTS*ADDR_W-1:0]   rf_waddr,
    output logic [WPORTS*DATA_W-1:0]   rf_wdata,
    input  logic [QPORTS*ADDR_W-1:0]   q_addr,
    output logic [QPORTS-1:0]          q_hit,
    output logic [QPORTS*DATA_W-1:0]   q_data,
    output logic                       busy
);

    localparam int unsigned PTR_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W     = $clog2(DEPTH + 1);
    localparam int unsigned READY_MAX = DEPTH - LANES;

    logic [ADDR_W-1:0] addr_q [DEPTH];
    logic [ADDR_W-1:0] addr_d [DEPTH];
    logic [DATA_W-1:0] data_q [DEPTH];
    logic [DATA_W-1:0] data_d [DEPTH];
    logic [PTR_W-1:0]  head_q, head_d, tail_q, tail_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [LANES-1:0]  keep_c;
    logic              accept_c;
    int unsigned       pop_c;

    // Pointer advance modulo DEPTH; off never exceeds DEPTH-1 so one wrap suffices.
    function automatic logic [PTR_W-1:0] ptr_add(input logic [PTR_W-1:0] base, input int unsigned off);
        int unsigned sum;
        sum = 32'(base) + off;
        if (sum >= DEPTH) sum = sum - DEPTH;
        return PTR_W'(sum);
    endfunction

    assign in_ready = (count_q <= CNT_W'(READY_MAX));
    assign accept_c = in_valid && in_ready;
    assign busy     = (count_q != '0);

    // A lane survives only if enabled, not x0, and not overwritten by a younger lane.
    always_comb begin
        keep_c = '0;
        for (int unsigned i = 0; i < LANES; i++) begin
            keep_c[i] = in_we[i] && (in_waddr[i*ADDR_W +: ADDR_W] != '0);
            for (int unsigned j = i + 1; j < LANES; j++) begin
                if (in_we[j] && (in_waddr[j*ADDR_W +: ADDR_W] == in_waddr[i*ADDR_W +: ADDR_W]))
                    keep_c[i] = 1'b0;
            end
        end
    end

    // Drain ports: an older entry is silenced when a younger popped entry hits the same register.
    always_comb begin
        logic [PTR_W-1:0] idx_k;
        logic [PTR_W-1:0] idx_m;
        idx_k    = '0;
        idx_m    = '0;
        rf_we    = '0;
        rf_waddr = '0;
        rf_wdata = '0;
        pop_c    = (32'(count_q) < WPORTS) ? 32'(count_q) : WPORTS;
        for (int unsigned k = 0; k < WPORTS; k++) begin
            if (k < pop_c) begin
                idx_k = ptr_add(head_q, k);
                rf_we[k]                    = 1'b1;
                rf_waddr[k*ADDR_W +: ADDR_W] = addr_q[idx_k];
                rf_wdata[k*DATA_W +: DATA_W] = data_q[idx_k];
                for (int unsigned m = k + 1; m < WPORTS; m++) begin
                    idx_m = ptr_add(head_q, m);
                    if ((m < pop_c) && (addr_q[idx_m] == addr_q[idx_k]))
                        rf_we[k] = 1'b0;
                end
            end
        end
    end

    // Bypass search from oldest to youngest so the youngest match wins.
    always_comb begin
        logic [PTR_W-1:0]  idx_j;
        logic [ADDR_W-1:0] qa;
        idx_j  = '0;
        qa     = '0;
        q_hit  = '0;
        q_data = '0;
        for (int unsigned p = 0; p < QPORTS; p++) begin
            qa = q_addr[p*ADDR_W +: ADDR_W];
            for (int unsigned j = 0; j < DEPTH; j++) begin
                idx_j = ptr_add(head_q, j);
                if ((j < 32'(count_q)) && (qa != '0) && (addr_q[idx_j] == qa)) begin
                    q_hit[p]                    = 1'b1;
                    q_data[p*DATA_W +: DATA_W] = data_q[idx_j];
                end
            end
        end
    end

    // Compact survivors onto the tail and advance pointers/count.
    always_comb begin
        int unsigned push;
        logic [PTR_W-1:0] idx_t;
        push   = 0;
        idx_t  = '0;
        addr_d = addr_q;
        data_d = data_q;
        if (accept_c) begin
            for (int unsigned i = 0; i < LANES; i++) begin
                if (keep_c[i]) begin
                    idx_t         = ptr_add(tail_q, push);
                    addr_d[idx_t] = in_waddr[i*ADDR_W +: ADDR_W];
                    data_d[idx_t] = in_wdata[i*DATA_W +: DATA_W];
                    push          = push + 1;
                end
            end
        end
        tail_d  = ptr_add(tail_q, push);
        head_d  = ptr_add(head_q, pop_c);
        count_d = CNT_W'(32'(count_q) + push - pop_c);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            for (int unsigned e = 0; e < DEPTH; e++) begin
                addr_q[e] <= '0;
                data_q[e] <= '0;
            end
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
        end
    end

endmodule

// File: tb/tb_wb_merge.sv
// Bench for wb_merge: directed scenarios plus randomized traffic against a queue model,
// on a 2-lane/1-port/4-deep instance and a 4-lane/2-port/7-deep instance.
module tb_wb_merge;

    typedef struct packed {
        logic [4:0]  a;
        logic [31:0] d;
    } wr_t;
    typedef wr_t wrq_t[$];

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic         v1;
    logic [1:0]   we1;
    logic [9:0]   wa1;
    logic [63:0]  wd1;
    logic         in_ready1, busy1;
    logic [0:0]   rf_we1;
    logic [4:0]   rf_waddr1;
    logic [31:0]  rf_wdata1;
    logic [1:0]   q_hit1;
    logic [63:0]  q_data1;

    logic         v2;
    logic [3:0]   we2;
    logic [19:0]  wa2;
    logic [127:0] wd2;
    logic         in_ready2, busy2;
    logic [1:0]   rf_we2;
    logic [9:0]   rf_waddr2;
    logic [63:0]  rf_wdata2;
    logic [1:0]   q_hit2;
    logic [63:0]  q_data2;

    logic [9:0]   qa;

    int total = 0;
    int bad   = 0;

    wrq_t mq1, mq2;
    logic        lw [4];
    logic [4:0]  la [4];
    logic [31:0] ld [4];

    wb_merge #(.LANES(2), .WPORTS(1), .DEPTH(4), .QPORTS(2), .ADDR_W(5), .DATA_W(32)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(v1), .in_ready(in_ready1),
        .in_we(we1), .in_waddr(wa1), .in_wdata(wd1),
        .rf_we(rf_we1), .rf_waddr(rf_waddr1), .rf_wdata(rf_wdata1),
        .q_addr(qa), .q_hit(q_hit1), .q_data(q_data1), .busy(busy1)
    );

    wb_merge #(.LANES(4), .WPORTS(2), .DEPTH(7), .QPORTS(2), .ADDR_W(5), .DATA_W(32)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .in_valid(v2), .in_ready(in_ready2),
        .in_we(we2), .in_waddr(wa2), .in_wdata(wd2),
        .rf_we(rf_we2), .rf_waddr(rf_waddr2), .rf_wdata(rf_wdata2),
        .q_addr(qa), .q_hit(q_hit2), .q_data(q_data2), .busy(busy2)
    );

    // Expected drain ports for a pending-write queue: first min(n,w) entries,
    // an entry is silent when a later popped entry targets the same register.
    function automatic void exp_rf(input wrq_t q, input int w, output logic [1:0] we,
                                   output logic [9:0] a, output logic [63:0] d);
        int pop;
        pop = (q.size() < w) ? q.size() : w;
        we = '0; a = '0; d = '0;
        for (int k = 0; k < pop; k++) begin
            we[k] = 1'b1;
            a[k*5 +: 5]   = q[k].a;
            d[k*32 +: 32] = q[k].d;
            for (int m = k + 1; m < pop; m++)
                if (q[m].a == q[k].a) we[k] = 1'b0;
        end
    endfunction

    // Expected {hit, data}: the youngest pending write to a non-zero address.
    function automatic logic [32:0] exp_q(input wrq_t q, input logic [4:0] a);
        logic [32:0] r;
        r = '0;
        if (a != 5'd0)
            for (int i = 0; i < q.size(); i++)
                if (q[i].a == a) r = {1'b1, q[i].d};
        return r;
    endfunction

    function automatic bit survives(input int i, input int n);
        if (!lw[i] || la[i] == 5'd0) return 1'b0;
        for (int j = i + 1; j < n; j++)
            if (lw[j] && la[j] == la[i]) return 1'b0;
        return 1'b1;
    endfunction

    task automatic idle();
        v1 = 1'b0; we1 = '0; wa1 = '0; wd1 = '0;
        v2 = 1'b0; we2 = '0; wa2 = '0; wd2 = '0;
        qa = '0;
    endtask

    task automatic reset_duts();
        idle();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
        mq1.delete();
        mq2.delete();
    endtask

    task automatic send1(input logic [1:0] we, input logic [4:0] a0, input logic [31:0] d0,
                         input logic [4:0] a1, input logic [31:0] d1);
        bit done;
        done = 1'b0;
        v1 = 1'b1; we1 = we; wa1 = {a1, a0}; wd1 = {d1, d0};
        for (int i = 0; i < 20 && !done; i++) begin
            done = in_ready1;
            @(posedge clk); #1;
        end
        v1 = 1'b0;
        total++;
        if (!done) begin bad++; $display("FAIL send1_timeout got=not_accepted exp=accepted"); end
    endtask

    task automatic send2(input logic [3:0] we, input logic [19:0] wa, input logic [127:0] wd);
        bit done;
        done = 1'b0;
        v2 = 1'b1; we2 = we; wa2 = wa; wd2 = wd;
        for (int i = 0; i < 20 && !done; i++) begin
            done = in_ready2;
            @(posedge clk); #1;
        end
        v2 = 1'b0;
        total++;
        if (!done) begin bad++; $display("FAIL send2_timeout got=not_accepted exp=accepted"); end
    endtask

    task automatic test_reset();
        reset_duts();
        total++; if (rf_we1 !== 1'b0)   begin bad++; $display("FAIL rst_rf_we1 got=%b exp=0", rf_we1); end
        total++; if (busy1 !== 1'b0)    begin bad++; $display("FAIL rst_busy1 got=%b exp=0", busy1); end
        total++; if (in_ready1 !== 1'b1) begin bad++; $display("FAIL rst_ready1 got=%b exp=1", in_ready1); end
        total++; if (rf_we2 !== 2'b00)  begin bad++; $display("FAIL rst_rf_we2 got=%b exp=00", rf_we2); end
        total++; if (in_ready2 !== 1'b1) begin bad++; $display("FAIL rst_ready2 got=%b exp=1", in_ready2); end
        v1 = 1'b1; we1 = 2'b11; wa1 = {5'd2, 5'd1}; wd1 = {32'h2, 32'h1};
        @(posedge clk); #1;
        wa1 = {5'd4, 5'd3}; wd1 = {32'h4, 32'h3};
        @(posedge clk); #1;
        v1 = 1'b0; qa = {5'd0, 5'd3};
        #1;
        total++; if (busy1 !== 1'b1 || rf_waddr1 !== 5'd2) begin bad++; $display("FAIL rst_preload got=%b/%0d exp=1/2", busy1, rf_waddr1); end
        total++; if (q_hit1[0] !== 1'b1) begin bad++; $display("FAIL rst_preload_q got=%b exp=1", q_hit1[0]); end
        #1 rst_n = 1'b0;
        #1;
        total++; if (rf_we1 !== 1'b0)    begin bad++; $display("FAIL rst_mid_rf_we got=%b exp=0", rf_we1); end
        total++; if (busy1 !== 1'b0)     begin bad++; $display("FAIL rst_mid_busy got=%b exp=0", busy1); end
        total++; if (in_ready1 !== 1'b1) begin bad++; $display("FAIL rst_mid_ready got=%b exp=1", in_ready1); end
        total++; if (q_hit1 !== 2'b00 || rf_waddr1 !== 5'd0) begin bad++; $display("FAIL rst_mid_q got=%b/%0d exp=00/0", q_hit1, rf_waddr1); end
        @(posedge clk); #1 rst_n = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(posedge clk); #1;
            total++; if (rf_we1 !== 1'b0) begin bad++; $display("FAIL rst_after_write c=%0d got=%b exp=0", c, rf_we1); end
        end
    endtask

    task automatic test_waw();
        reset_duts();
        v1 = 1'b1; we1 = 2'b11; wa1 = {5'd5, 5'd5}; wd1 = {32'h22, 32'h11};
        @(posedge clk); #1;
        v1 = 1'b0;
        total++; if (rf_we1 !== 1'b1 || rf_waddr1 !== 5'd5 || rf_wdata1 !== 32'h22)
            begin bad++; $display("FAIL waw_write got=%b x%0d=%h exp=1 x5=22", rf_we1, rf_waddr1, rf_wdata1); end
        total++; if (busy1 !== 1'b1) begin bad++; $display("FAIL waw_busy got=%b exp=1", busy1); end
        @(posedge clk); #1;
        total++; if (rf_we1 !== 1'b0 || busy1 !== 1'b0) begin bad++; $display("FAIL waw_after got=%b/%b exp=0/0", rf_we1, busy1); end
    endtask

    task automatic test_x0();
        reset_duts();
        v1 = 1'b1; we1 = 2'b01; wa1 = {5'd3, 5'd0}; wd1 = {32'h33, 32'hFF};
        total++; if (in_ready1 !== 1'b1) begin bad++; $display("FAIL x0_ready got=%b exp=1", in_ready1); end
        @(posedge clk); #1;
        v1 = 1'b0;
        for (int c = 0; c < 3; c++) begin
            total++; if (busy1 !== 1'b0 || rf_we1 !== 1'b0)
                begin bad++; $display("FAIL x0_quiet c=%0d got=%b/%b exp=0/0", c, busy1, rf_we1); end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_back_to_back();
        logic [36:0] got[$];
        int  b;
        bit  acc, saw_stall;
        reset_duts();
        b = 0; saw_stall = 1'b0;
        v1 = 1'b1; we1 = 2'b11; wa1 = {5'd2, 5'd1}; wd1 = {32'h2, 32'h1};
        for (int c = 0; c < 40; c++) begin
            acc = v1 && in_ready1;
            if (v1 && !in_ready1) saw_stall = 1'b1;
            @(posedge clk); #1;
            if (rf_we1[0]) got.push_back({rf_waddr1, rf_wdata1});
            if (acc) begin
                b++;
                if (b < 4) begin
                    wa1 = {5'(2*b + 2), 5'(2*b + 1)};
                    wd1 = {32'(2*b + 2), 32'(2*b + 1)};
                end else v1 = 1'b0;
            end
        end
        v1 = 1'b0;
        total++; if (got.size() != 8) begin bad++; $display("FAIL b2b_count got=%0d exp=8", got.size()); end
        total++; if (!saw_stall) begin bad++; $display("FAIL b2b_stall got=no_stall exp=stall"); end
        for (int i = 0; i < 8 && i < got.size(); i++) begin
            total++; if (got[i] !== {5'(i + 1), 32'(i + 1)})
                begin bad++; $display("FAIL b2b_order i=%0d got=%h exp=%h", i, got[i], {5'(i + 1), 32'(i + 1)}); end
        end
    endtask

    task automatic test_collision();
        reset_duts();
        send2(4'b0111, {5'd0, 5'd9, 5'd2, 5'd1}, {32'h0, 32'hA, 32'h2, 32'h1});
        total++; if (rf_we2 !== 2'b11) begin bad++; $display("FAIL coll_first got=%b exp=11", rf_we2); end
        send2(4'b0001, {5'd0, 5'd0, 5'd0, 5'd9}, {32'h0, 32'h0, 32'h0, 32'hB});
        total++; if (rf_we2 !== 2'b10) begin bad++; $display("FAIL coll_we got=%b exp=10", rf_we2); end
        total++; if (rf_waddr2[9:5] !== 5'd9 || rf_wdata2[63:32] !== 32'hB)
            begin bad++; $display("FAIL coll_port1 got=x%0d=%h exp=x9=b", rf_waddr2[9:5], rf_wdata2[63:32]); end
        @(posedge clk); #1;
        total++; if (busy2 !== 1'b0 || rf_we2 !== 2'b00) begin bad++; $display("FAIL coll_drained got=%b/%b exp=0/00", busy2, rf_we2); end
    endtask

    task automatic test_bypass();
        reset_duts();
        qa = {5'd0, 5'd7};
        send1(2'b11, 5'd1, 32'h1, 5'd2, 32'h2);
        send1(2'b11, 5'd3, 32'h3, 5'd7, 32'hAB);
        #1;
        total++; if (q_hit1[0] !== 1'b1 || q_data1[31:0] !== 32'hAB)
            begin bad++; $display("FAIL byp_first got=%b/%h exp=1/ab", q_hit1[0], q_data1[31:0]); end
        total++; if (in_ready1 !== 1'b0) begin bad++; $display("FAIL byp_full got=%b exp=0", in_ready1); end
        send1(2'b01, 5'd7, 32'hCD, 5'd0, 32'h0);
        #1;
        total++; if (q_hit1[0] !== 1'b1 || q_data1[31:0] !== 32'hCD)
            begin bad++; $display("FAIL byp_newer got=%b/%h exp=1/cd", q_hit1[0], q_data1[31:0]); end
        total++; if (q_hit1[1] !== 1'b0) begin bad++; $display("FAIL byp_x0 got=%b exp=0", q_hit1[1]); end
        @(posedge clk); #1;
        total++; if (rf_waddr1 !== 5'd7 || rf_wdata1 !== 32'hCD || q_data1[31:0] !== 32'hCD)
            begin bad++; $display("FAIL byp_drain got=x%0d=%h q=%h exp=x7=cd q=cd", rf_waddr1, rf_wdata1, q_data1[31:0]); end
        @(posedge clk); #1;
        total++; if (q_hit1[0] !== 1'b0 || busy1 !== 1'b0) begin bad++; $display("FAIL byp_gone got=%b/%b exp=0/0", q_hit1[0], busy1); end
    endtask

    task automatic test_random();
        logic [1:0]  ewe;
        logic [9:0]  ea;
        logic [63:0] ed;
        logic [32:0] eq;
        bit acc1, acc2;
        wr_t e;
        reset_duts();
        for (int c = 0; c < 500; c++) begin
            for (int i = 0; i < 4; i++) begin
                lw[i] = ($urandom_range(0, 3) != 0);
                la[i] = 5'($urandom_range(0, 7));
                ld[i] = $urandom;
            end
            v1 = ($urandom_range(0, 3) != 0);
            v2 = ($urandom_range(0, 3) != 0);
            we1 = {lw[1], lw[0]}; wa1 = {la[1], la[0]}; wd1 = {ld[1], ld[0]};
            we2 = {lw[3], lw[2], lw[1], lw[0]}; wa2 = {la[3], la[2], la[1], la[0]};
            wd2 = {ld[3], ld[2], ld[1], ld[0]};
            qa = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
            #1;
            exp_rf(mq1, 1, ewe, ea, ed);
            total++; if ({rf_we1, rf_waddr1, rf_wdata1} !== {ewe[0], ea[4:0], ed[31:0]})
                begin bad++; $display("FAIL rnd_rf1 c=%0d got=%b x%0d=%h exp=%b x%0d=%h", c, rf_we1, rf_waddr1, rf_wdata1, ewe[0], ea[4:0], ed[31:0]); end
            total++; if (busy1 !== (mq1.size() != 0) || in_ready1 !== (mq1.size() <= 2))
                begin bad++; $display("FAIL rnd_flags1 c=%0d got=%b/%b n=%0d", c, busy1, in_ready1, mq1.size()); end
            exp_rf(mq2, 2, ewe, ea, ed);
            total++; if ({rf_we2, rf_waddr2, rf_wdata2} !== {ewe, ea, ed})
                begin bad++; $display("FAIL rnd_rf2 c=%0d got=%b %h %h exp=%b %h %h", c, rf_we2, rf_waddr2, rf_wdata2, ewe, ea, ed); end
            total++; if (busy2 !== (mq2.size() != 0) || in_ready2 !== (mq2.size() <= 3))
                begin bad++; $display("FAIL rnd_flags2 c=%0d got=%b/%b n=%0d", c, busy2, in_ready2, mq2.size()); end
            for (int p = 0; p < 2; p++) begin
                eq = exp_q(mq1, qa[p*5 +: 5]);
                total++; if ({q_hit1[p], q_data1[p*32 +: 32]} !== eq)
                    begin bad++; $display("FAIL rnd_q1 c=%0d p=%0d got=%b/%h exp=%h", c, p, q_hit1[p], q_data1[p*32 +: 32], eq); end
                eq = exp_q(mq2, qa[p*5 +: 5]);
                total++; if ({q_hit2[p], q_data2[p*32 +: 32]} !== eq)
                    begin bad++; $display("FAIL rnd_q2 c=%0d p=%0d got=%b/%h exp=%h", c, p, q_hit2[p], q_data2[p*32 +: 32], eq); end
            end
            acc1 = v1 && (mq1.size() <= 2);
            acc2 = v2 && (mq2.size() <= 3);
            @(posedge clk);
            if (mq1.size() > 0) void'(mq1.pop_front());
            for (int k = 0; k < 2 && mq2.size() > 0; k++) void'(mq2.pop_front());
            if (acc1) for (int i = 0; i < 2; i++) if (survives(i, 2)) begin e = {la[i], ld[i]}; mq1.push_back(e); end
            if (acc2) for (int i = 0; i < 4; i++) if (survives(i, 4)) begin e = {la[i], ld[i]}; mq2.push_back(e); end
            #1;
        end
        idle();
    endtask

    initial begin
        idle();
        test_reset();
        test_waw();
        test_x0();
        test_back_to_back();
        test_collision();
        test_bypass();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/wb_merge.md
# wb_merge

Parametrised multi-lane writeback merge stage for the multi-issue pipeline. It sits between the last execute/memory stage and the register file. It accepts one bundle of up to LANES register writes per cycle. It cancels write-after-write losers and x0 writes, then queues the surviving writes in a small in-order buffer and drains up to WPORTS of them per cycle into the register file write ports. A bypass query port lets decode read values that are still pending in the buffer.

## Interface
- LANES, 2, issue lanes per bundle; lane 0 is oldest in program order
- WPORTS, 1, register file write ports; 1 <= WPORTS <= LANES
- DEPTH, 4, buffer entries; DEPTH >= LANES
- QPORTS, 2, bypass query ports
- ADDR_W, 5, register address width
- DATA_W, 32, register data width

- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  bundle present
- in_ready  out  1  bundle accepted when in_valid & in_ready at clk edge
- in_we  in  LANES  per-lane write enable
- in_waddr  in  LANES*ADDR_W  per-lane destination; lane i at [i*ADDR_W +: ADDR_W]
- in_wdata  in  LANES*DATA_W  per-lane data, same packing
- rf_we  out  WPORTS  write-port enable
- rf_waddr  out  WPORTS*ADDR_W  write-port address
- rf_wdata  out  WPORTS*DATA_W  write-port data
- q_addr  in  QPORTS*ADDR_W  bypass query address
- q_hit  out  QPORTS  a pending write exists for q_addr
- q_data  out  QPORTS*DATA_W  data of the youngest pending write to q_addr
- busy  out  1  buffer non-empty

## Operation
- Lane filter (combinational): lane i survives iff in_we[i], in_waddr[i] != 0, and no lane j > i has in_we[j] & in_waddr[j] == in_waddr[i].
- Surviving lanes are compacted in ascending lane order and pushed at the tail of the buffer at the accept edge. push = number of survivors (0..LANES). A bundle with zero survivors is accepted and has no effect.
- Buffer: circular, DEPTH entries {addr, data}. Head/tail pointers wrap modulo DEPTH. count is held in a register.
- in_ready = (count <= DEPTH - LANES), derived from the registered count only. It does not depend on in_valid or on the drain in the same cycle, so a push can never overflow.
- Drain: pop = min(count, WPORTS). Port k presents entry head+k when k < count; otherwise rf_we[k] = 0.
- Drain collision: within one cycle, rf_we[k] is cleared if some port m > k with m < pop carries the same address. The cleared entry is still popped. The register file therefore never sees two writes to one address in one cycle.
- count_next = count + push − pop. Simultaneous push and pop are always legal.
- Query: q_hit[p] = 1 iff some valid entry has addr == q_addr[p] and q_addr[p] != 0. q_data[p] is the data of the youngest such entry (nearest the tail). Entries being drained this cycle are still searched. This path is combinational. Accepts on in_valid in the same cycle are not visible to queries.
- busy = (count != 0).

## Timing
- Reset (asynchronous assert, synchronous-safe release): count = 0, head = tail = 0, entry storage cleared to 0. While in reset: rf_we = 0, rf_waddr = 0, rf_wdata = 0, q_hit = 0, q_data = 0, busy = 0, in_ready = 1.
- Reset mid-operation discards all pending writes; nothing is written to the register file after rst_n falls.
- Latency: a bundle accepted at edge t appears on rf_* from t+1, at the earliest. The register file captures it at edge t+1, provided it sits within the first WPORTS entries.
- Throughput: sustained WPORTS writes per cycle. in_ready drops for as many cycles as needed to drain below DEPTH − LANES + 1.
- Order: writes leave in program order, and across bundles in acceptance order.
- rf_* and busy come from registered state only; q_* depend on q_addr combinationally.

## Test plan
- Reset: with LANES=2, WPORTS=1, DEPTH=4, load 3 entries, then pull rst_n low mid-cycle → rf_we=0 and busy=0 immediately, in_ready=1; after release there are no further rf writes.
- WAW in bundle: in_we=2'b11, lanes {x5=0x11, x5=0x22} → exactly one write, x5=0x22, one cycle after accept; busy high for that cycle only.
- x0 and disabled lanes: lanes {x0=0xFF, we=0 x3=0x33} → accepted, busy stays 0, rf_we never asserts.
- Back-pressure: DEPTH=4, LANES=2, WPORTS=1; present 4 back-to-back bundles of distinct writes x1..x8 = 0x1..0x8 → in_ready falls when count=3; all 8 writes appear, one per cycle, in order x1..x8, with no loss or duplicate.
- Drain collision: WPORTS=2; bundle A {x9=0xA}, next bundle B {x9=0xB} both queued before drain → only port 1 writes x9=0xB; the port 0 entry is popped silently.
- Bypass: queue x7=0xAB behind two stalled entries, q_addr=7 → q_hit=1, q_data=0xAB. After a newer x7=0xCD is queued → q_data=0xCD. After it drains → q_hit=0. q_addr=0 → q_hit=0 always.
